// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the systolic-array output FIFO controller.
//   ctrl_state_t : sequencing states of the controller FSM
//   cnt_width()  : counter width able to hold the value 'depth' itself
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_DRAIN,
        S_FLUSH,
        S_FIN
    } ctrl_state_t;

    // A counter that is loaded with 'depth' needs to represent depth, not
    // depth-1, so size it for depth+1 distinct values.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_array_ctrl_rd_valid_pipe.sv
// -----------------------------------------------------------------------------
// rd_valid_pipe
// Delays the FIFO read strobe by the FIFO array's read latency so that
// out_valid lines up with valid data on the array's data_out.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   flush     : synchronous clear of every in-flight read (abort)
//   rd_en     : read strobe issued to the FIFO array
//   out_valid : rd_en delayed by RD_LATENCY cycles (same cycle when 0)
// -----------------------------------------------------------------------------
module rd_valid_pipe #(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic rd_en,
    output logic out_valid
);

    generate
        if (RD_LATENCY == 0) begin : g_comb
            // Zero-latency array: data is valid in the same cycle as the read.
            logic unused_inputs;
            assign unused_inputs = clk ^ rst_n ^ flush;
            assign out_valid     = rd_en;
        end else begin : g_pipe
            logic [RD_LATENCY-1:0] stage;

            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    stage <= '0;
                end else begin
                    stage[0] <= rd_en;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign out_valid = stage[RD_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/fifo_array_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_array_ctrl
// Sequences the FIFO array that buffers systolic-array output rows. One
// transaction per tile: clear pointers, fill n words, drain n words.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start, num_words      : scheduler request and word count (sampled in IDLE)
//   abort                 : cancel the running transaction (busy states)
//   in_valid / in_ready   : upstream handshake on the array's data_in
//   out_ready / out_valid : downstream read throttle / valid array data_out
//   fifo_rd_clr/wr_clr    : pointer clears to the FIFO array
//   fifo_wr_en/rd_en      : write / read strobes to the FIFO array
//   busy, done            : scheduler status (done is a one-cycle pulse)
//   words_left            : words still to write (FILL) or issue (DRAIN)
// -----------------------------------------------------------------------------
module fifo_array_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int CNT_WIDTH     = cnt_width(SYSTOLIC_SIZE),
    parameter int RD_LATENCY    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_words,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic                 fifo_rd_clr,
    output logic                 fifo_wr_clr,
    output logic                 fifo_wr_en,
    output logic                 fifo_rd_en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] words_left
);

    localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

    ctrl_state_t          state;
    logic [CNT_WIDTH-1:0] n_words;      // clamped size of the running transaction
    logic [CNT_WIDTH-1:0] num_clamped;
    logic                 abort_hit;
    logic                 last_word;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path through it can leave a value held (no latch).
    always_comb begin
        abort_hit   = 1'b0;
        in_ready    = 1'b0;
        fifo_wr_en  = 1'b0;
        fifo_rd_en  = 1'b0;
        num_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
        last_word   = (words_left == ONE);

        // Abort only means something once a transaction is under way.
        abort_hit = abort && (state inside {S_CLEAR, S_FILL, S_DRAIN, S_FLUSH});

        if (state == S_FILL) begin
            in_ready   = (words_left != '0);
            fifo_wr_en = in_ready && in_valid && !abort_hit;
        end

        if (state == S_DRAIN) begin
            fifo_rd_en = out_ready && (words_left != '0) && !abort_hit;
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_INIT;
            n_words     <= '0;
            words_left  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fifo_rd_clr <= 1'b0;
            fifo_wr_clr <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                // After reset release the clears are raised for one cycle;
                // the raised clear marks that the pulse has been issued.
                S_INIT: begin
                    if (!fifo_wr_clr) begin
                        fifo_rd_clr <= 1'b1;
                        fifo_wr_clr <= 1'b1;
                        busy        <= 1'b1;
                    end else begin
                        fifo_rd_clr <= 1'b0;
                        fifo_wr_clr <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (start) begin
                        n_words     <= num_clamped;
                        fifo_rd_clr <= 1'b1;
                        fifo_wr_clr <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_CLEAR;
                    end
                end

                // Clears stay high straight into FIN when nothing is to move.
                S_CLEAR: begin
                    if (abort_hit || (n_words == '0)) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        fifo_rd_clr <= 1'b0;
                        fifo_wr_clr <= 1'b0;
                        words_left  <= n_words;
                        state       <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (abort_hit) begin
                        words_left  <= '0;
                        fifo_rd_clr <= 1'b1;
                        fifo_wr_clr <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_FIN;
                    end else if (fifo_wr_en) begin
                        if (last_word) begin
                            words_left <= n_words;   // reload for the drain phase
                            state      <= S_DRAIN;
                        end else begin
                            words_left <= words_left - ONE;
                        end
                    end
                end

                S_DRAIN: begin
                    if (abort_hit) begin
                        words_left  <= '0;
                        fifo_rd_clr <= 1'b1;
                        fifo_wr_clr <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_FIN;
                    end else if (fifo_rd_en) begin
                        if (last_word) begin
                            words_left <= '0;
                            // With a zero-latency array the last word is
                            // already out, so there is nothing to flush.
                            if (RD_LATENCY == 0) begin
                                fifo_rd_clr <= 1'b1;
                                fifo_wr_clr <= 1'b1;
                                done        <= 1'b1;
                                state       <= S_FIN;
                            end else begin
                                state <= S_FLUSH;
                            end
                        end else begin
                            words_left <= words_left - ONE;
                        end
                    end
                end

                // One cycle covers the supported read latency of 1; abort
                // lands in FIN on the same edge.
                S_FLUSH: begin
                    fifo_rd_clr <= 1'b1;
                    fifo_wr_clr <= 1'b1;
                    done        <= 1'b1;
                    state       <= S_FIN;
                end

                S_FIN: begin
                    fifo_rd_clr <= 1'b0;
                    fifo_wr_clr <= 1'b0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end

                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    rd_valid_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_valid_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort_hit),
        .rd_en     (fifo_rd_en),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_fifo_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_array_ctrl
// Drives fifo_array_ctrl with randomized upstream/downstream handshakes and
// checks it against a transaction-level reference: n = min(num_words, 16)
// writes then n reads, out_valid one cycle after each read, data returned in
// upstream order from a behavioural FIFO array driven by the DUT strobes.
// -----------------------------------------------------------------------------
module tb_fifo_array_ctrl;

    localparam int SZ = 16;
    localparam int CW = 5;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_words;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          out_ready;
    logic          out_valid;
    logic          fifo_rd_clr;
    logic          fifo_wr_clr;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_left;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO array controlled only by the DUT strobes.
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] mem [SZ];
    int         wptr = 0;
    int         rptr = 0;

    always #5 clk = ~clk;

    fifo_array_ctrl #(
        .SYSTOLIC_SIZE (SZ),
        .CNT_WIDTH     (CW),
        .RD_LATENCY    (RL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_words   (num_words),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .fifo_rd_clr (fifo_rd_clr),
        .fifo_wr_clr (fifo_wr_clr),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_rd_en  (fifo_rd_en),
        .busy        (busy),
        .done        (done),
        .words_left  (words_left)
    );

    always @(posedge clk) begin
        if (fifo_wr_clr) begin
            wptr <= 0;
        end else if (fifo_wr_en) begin
            mem[wptr % SZ] <= data_in;
            wptr <= wptr + 1;
        end
        if (fifo_rd_clr) begin
            rptr <= 0;
        end else if (fifo_rd_en) begin
            data_out <= mem[rptr % SZ];
            rptr <= rptr + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 2 ns after the rising edge; outputs are sampled 4 ns after.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Hold reset for 'hold' edges, release it, expect one clear pulse then IDLE.
    task automatic test_reset(input int hold);
        set_idle();
        rst_n = 1'b0;
        for (int i = 0; i < hold; i++) begin
            next_cycle();
            #2;
            checks++;
            if ({busy, done, fifo_rd_clr, fifo_wr_clr, out_valid} !== 5'b0 || words_left !== '0) begin
                errors++;
                $display("FAIL reset_outputs: busy=%b done=%b clr=%b%b out_valid=%b words_left=%0d, all must be 0",
                         busy, done, fifo_rd_clr, fifo_wr_clr, out_valid, words_left);
            end
            checks++;
            if ({in_ready, fifo_wr_en, fifo_rd_en} !== 3'b0) begin
                errors++;
                $display("FAIL reset_enables: in_ready=%b wr_en=%b rd_en=%b, all must be 0", in_ready, fifo_wr_en, fifo_rd_en);
            end
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        #2;
        checks++;
        if ({fifo_rd_clr, fifo_wr_clr} !== 2'b11 || {fifo_wr_en, fifo_rd_en} !== 2'b00) begin
            errors++;
            $display("FAIL init_clr_pulse: clr=%b%b en=%b%b, required clr=11 en=00",
                     fifo_rd_clr, fifo_wr_clr, fifo_wr_en, fifo_rd_en);
        end
        next_cycle();
        #2;
        checks++;
        if ({fifo_rd_clr, fifo_wr_clr, busy, done, fifo_wr_en, fifo_rd_en, in_ready} !== 7'b0) begin
            errors++;
            $display("FAIL init_to_idle: clr=%b%b busy=%b done=%b en=%b%b in_ready=%b, all must be 0",
                     fifo_rd_clr, fifo_wr_clr, busy, done, fifo_wr_en, fifo_rd_en, in_ready);
        end
    endtask

    // One complete transaction with randomized handshakes. abort_wr/abort_rd
    // raise abort when that many writes/reads have happened (-1: never);
    // hold_lo forces out_ready low for 3 drain cycles starting there.
    task automatic run_txn(input int num, input int abort_wr, input int abort_rd,
                           input int pv, input int pr, input bit toggle_valid,
                           input int hold_lo, input bit start_in_drain);
        int         n, writes, reads, drain_cyc, cyc, exp_w, exp_r;
        bit         prev_rd, aborted, abort_in_fill, in_fill;
        logic [7:0] exp_q [$];
        logic [7:0] exp_word;

        n = (num > SZ) ? SZ : num;
        writes = 0; reads = 0; drain_cyc = 0; cyc = 0;
        prev_rd = 1'b0; aborted = 1'b0; abort_in_fill = 1'b0;

        next_cycle();
        set_idle();
        start     = 1'b1;
        num_words = CW'(num);
        #2;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_start: busy=%b, required 0", busy);
        end

        next_cycle();
        set_idle();
        #2;
        checks++;
        if ({fifo_rd_clr, fifo_wr_clr, busy, done} !== 4'b1110) begin
            errors++;
            $display("FAIL clear_flags: clr=%b%b busy=%b done=%b, required 1 1 1 0", fifo_rd_clr, fifo_wr_clr, busy, done);
        end
        checks++;
        if ({fifo_wr_en, fifo_rd_en, in_ready, out_valid} !== 4'b0 || words_left !== '0) begin
            errors++;
            $display("FAIL clear_quiet: en=%b%b in_ready=%b out_valid=%b words_left=%0d, required all 0",
                     fifo_wr_en, fifo_rd_en, in_ready, out_valid, words_left);
        end

        while ((writes < n || reads < n) && !aborted && cyc < 400) begin
            in_fill = (writes < n);
            next_cycle();
            set_idle();
            data_in = 8'($urandom);
            if (in_fill) in_valid = toggle_valid ? (cyc % 2 == 0) : ($urandom_range(99) < pv);
            else         in_valid = ($urandom_range(1) == 1);
            if (!in_fill && hold_lo >= 0 && drain_cyc >= hold_lo && drain_cyc < hold_lo + 3) out_ready = 1'b0;
            else out_ready = ($urandom_range(99) < pr);
            if (in_fill && writes == abort_wr) abort = 1'b1;
            if (!in_fill && reads == abort_rd) abort = 1'b1;
            if (!in_fill && start_in_drain && drain_cyc == 0) begin
                start     = 1'b1;
                num_words = CW'(2);
            end
            #2;
            checks++;
            if (fifo_wr_en === 1'b1 && fifo_rd_en === 1'b1) begin
                errors++;
                $display("FAIL wr_rd_exclusive: wr_en=1 rd_en=1, required never both");
            end
            if (in_fill) begin
                checks++;
                if (fifo_wr_en !== (in_valid && !abort)) begin
                    errors++;
                    $display("FAIL fill_wr_en: got %b required %b (in_valid=%b abort=%b)", fifo_wr_en, in_valid && !abort, in_valid, abort);
                end
                checks++;
                if (in_ready !== 1'b1 || fifo_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_ready: in_ready=%b rd_en=%b, required 1 0", in_ready, fifo_rd_en);
                end
                checks++;
                if (words_left !== CW'(n - writes)) begin
                    errors++;
                    $display("FAIL fill_words_left: got %0d required %0d", words_left, n - writes);
                end
            end else begin
                checks++;
                if (fifo_rd_en !== (out_ready && !abort)) begin
                    errors++;
                    $display("FAIL drain_rd_en: got %b required %b (out_ready=%b abort=%b)", fifo_rd_en, out_ready && !abort, out_ready, abort);
                end
                checks++;
                if (in_ready !== 1'b0 || fifo_wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_no_write: in_ready=%b wr_en=%b, required 0 0", in_ready, fifo_wr_en);
                end
                checks++;
                if (words_left !== CW'(n - reads)) begin
                    errors++;
                    $display("FAIL drain_words_left: got %0d required %0d", words_left, n - reads);
                end
            end
            checks++;
            if (out_valid !== prev_rd) begin
                errors++;
                $display("FAIL out_valid_lag: got %b required %b", out_valid, prev_rd);
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_underflow: out_valid with no word outstanding");
                end else begin
                    exp_word = exp_q.pop_front();
                    if (data_out !== exp_word) begin
                        errors++;
                        $display("FAIL read_order: data_out=%h required %h", data_out, exp_word);
                    end
                end
            end
            if (fifo_wr_en === 1'b1) begin
                exp_q.push_back(data_in);
                writes++;
            end
            if (fifo_rd_en === 1'b1) reads++;
            prev_rd = (fifo_rd_en === 1'b1);
            if (!in_fill) drain_cyc++;
            if (abort) begin
                aborted       = 1'b1;
                abort_in_fill = in_fill;
            end
            cyc++;
        end
        checks++;
        if (cyc >= 400) begin
            errors++;
            $display("FAIL txn_timeout: writes=%0d reads=%0d after %0d cycles, required %0d each", writes, reads, cyc, n);
        end

        next_cycle();
        set_idle();
        #2;
        if (!aborted && n > 0) begin
            // Flush cycle: last word delivered, no new strobes, not done yet.
            checks++;
            if (out_valid !== 1'b1 || {done, busy, fifo_wr_en, fifo_rd_en} !== 4'b0100) begin
                errors++;
                $display("FAIL flush_cycle: out_valid=%b done=%b busy=%b en=%b%b, required 1 0 1 00",
                         out_valid, done, busy, fifo_wr_en, fifo_rd_en);
            end
            if (out_valid === 1'b1 && exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                checks++;
                if (data_out !== exp_word) begin
                    errors++;
                    $display("FAIL last_word: data_out=%h required %h", data_out, exp_word);
                end
            end
            next_cycle();
            #2;
        end
        checks++;
        if ({done, busy, fifo_rd_clr, fifo_wr_clr} !== 4'b1111) begin
            errors++;
            $display("FAIL fin_flags: done=%b busy=%b clr=%b%b, required 1 1 11", done, busy, fifo_rd_clr, fifo_wr_clr);
        end
        checks++;
        if ({out_valid, fifo_wr_en, fifo_rd_en} !== 3'b0 || words_left !== '0) begin
            errors++;
            $display("FAIL fin_quiet: out_valid=%b en=%b%b words_left=%0d, required all 0",
                     out_valid, fifo_wr_en, fifo_rd_en, words_left);
        end

        next_cycle();
        #2;
        checks++;
        if ({done, busy, fifo_rd_clr, fifo_wr_clr, out_valid} !== 5'b0) begin
            errors++;
            $display("FAIL back_to_idle: done=%b busy=%b clr=%b%b out_valid=%b, required all 0",
                     done, busy, fifo_rd_clr, fifo_wr_clr, out_valid);
        end

        exp_w = aborted ? (abort_in_fill ? abort_wr : n) : n;
        exp_r = aborted ? (abort_in_fill ? 0 : abort_rd) : n;
        checks++;
        if (writes != exp_w || reads != exp_r) begin
            errors++;
            $display("FAIL strobe_counts: writes=%0d reads=%0d, required %0d %0d", writes, reads, exp_w, exp_r);
        end
    endtask

    task automatic test_full_tile();
        run_txn(16, -1, -1, 100, 100, 1'b0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn(5, -1, -1, 100, 100, 1'b1, 1, 1'b0);
    endtask

    task automatic test_clamp_zero();
        run_txn(20, -1, -1, 100, 100, 1'b0, -1, 1'b0);
        run_txn(0, -1, -1, 100, 100, 1'b0, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_txn(10, 7, -1, 100, 100, 1'b0, -1, 1'b0);
        run_txn(3, -1, -1, 100, 100, 1'b0, -1, 1'b0);
        run_txn(6, -1, 2, 100, 100, 1'b0, -1, 1'b0);
        run_txn(4, -1, -1, 70, 70, 1'b0, -1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_txn(8, -1, -1, 100, 100, 1'b0, -1, 1'b1);
    endtask

    task automatic test_reset_mid_fill();
        next_cycle();
        set_idle();
        start     = 1'b1;
        num_words = CW'(10);
        next_cycle();
        set_idle();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            in_valid = 1'b1;
            data_in  = 8'($urandom);
        end
        next_cycle();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        next_cycle();
        #2;
        checks++;
        if ({busy, done, fifo_rd_clr, fifo_wr_clr, out_valid, in_ready, fifo_wr_en, fifo_rd_en} !== 8'b0 || words_left !== '0) begin
            errors++;
            $display("FAIL reset_mid_fill: busy=%b done=%b clr=%b%b out_valid=%b in_ready=%b en=%b%b words_left=%0d, required all 0",
                     busy, done, fifo_rd_clr, fifo_wr_clr, out_valid, in_ready, fifo_wr_en, fifo_rd_en, words_left);
        end
        test_reset(2);
        run_txn(5, -1, -1, 100, 100, 1'b0, -1, 1'b0);
    endtask

    task automatic test_random();
        int num, r, awr, ard;
        for (int t = 0; t < 10; t++) begin
            num = int'($urandom_range(20));
            r   = int'($urandom_range(3));
            awr = (r == 0) ? int'($urandom_range(15)) : -1;
            ard = (r == 1) ? int'($urandom_range(15)) : -1;
            run_txn(num, awr, ard, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 1'b0, -1, 1'b0);
        end
    endtask

    initial begin
        set_idle();
        rst_n     = 1'b0;
        num_words = '0;
        data_in   = '0;
        test_reset(3);
        test_full_tile();
        test_backpressure();
        test_clamp_zero();
        test_abort();
        test_start_while_busy();
        test_reset_mid_fill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
